// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side consumer for the dual-clock FIFO. It issues FIFO reads, absorbs
// the FIFO's one-cycle registered read latency and re-presents the words as a
// first-word-fall-through valid/ready stream. A two-entry head/tail buffer
// plus the in-flight read slot keeps one word per cycle flowing under
// backpressure without ever dropping a word.
module fifo_stream_reader #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_r_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_level
);

  // Buffer state: occupancy, read-in-flight flag, head/tail entries.
  logic [1:0]        occ_reg;
  logic [1:0]        occ_next;
  logic              pend_reg;
  logic [DATA_W-1:0] head_reg;
  logic [DATA_W-1:0] head_next;
  logic [DATA_W-1:0] tail_reg;
  logic [DATA_W-1:0] tail_next;

  logic              pop;
  logic [2:0]        room;
  logic [1:0]        occ_post;

  // A word leaves whenever the head is valid and the sink takes it.
  assign m_valid = (occ_reg != 2'd0);
  assign pop     = m_valid & m_ready;

  // Slots committed after this cycle: held words plus the word in flight,
  // minus the one leaving now. Computed at 3 bits so the subtraction of a
  // pop never wraps.
  assign room = {1'b0, occ_reg} + {2'b00, pend_reg} - {2'b00, pop};

  // Only read when a slot is guaranteed next cycle. rst_n gates the request
  // so no read is taken from the FIFO while this block is held in reset.
  assign fifo_r_en = rst_n & ~fifo_empty & ~flush & (room < 3'd2);

  // Occupancy once this cycle's pop has been applied.
  assign occ_post = occ_reg - {1'b0, pop};

  assign m_data  = head_reg;
  assign m_level = occ_reg;

  // Next buffer contents: pop shifts tail into head, then an arriving word
  // fills the first free entry. occ_post=1 with an arrival cannot coincide
  // with occ=2 plus pend, so a tail write never clobbers a live word.
  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    occ_next  = occ_post + {1'b0, pend_reg};
    if (pop) begin
      head_next = tail_reg;
    end
    if (pend_reg && !flush) begin
      if (occ_post == 2'd0) begin
        head_next = fifo_r_data;
      end else begin
        tail_next = fifo_r_data;
      end
    end
    if (flush) begin
      occ_next = 2'd0;
    end
  end

  // State registers; flush empties the buffer and forgets the in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg  <= 2'd0;
      pend_reg <= 1'b0;
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      occ_reg  <= occ_next;
      pend_reg <= fifo_r_en;
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

endmodule
